// File: rtl/uart_echo_tester.sv
// uart_echo_tester: host-side initiator for the UART increment-echo responder.
// Sends SEED, SEED+1, ... one byte at a time, waits for each reply (or a timeout),
// and scores the reply against sent+1, tallying ok / error / timed-out exchanges.
module uart_echo_tester #(
  parameter logic [7:0]  SEED    = 8'h00,
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned TO_W    = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] num_bytes,
  input  logic       tx_done_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] r_data,
  output logic       tx_start,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       done,
  output logic [8:0] ok_cnt,
  output logic [8:0] err_cnt,
  output logic [8:0] to_cnt
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_RX, CHECK} state_t;

  localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_nx;
  logic [TO_W-1:0] timer;
  logic [8:0]      remaining;
  logic [7:0]      rx_byte;
  logic            timed_out;
  logic            done_r;
  logic            timer_exp;
  logic [7:0]      expected;

  assign timer_exp = (timer == TIMER_LAST);
  assign expected  = w_data + 8'd1;

  assign tx_start = (state == SEND);
  assign busy     = (state != IDLE);
  // done is registered so it coincides with the counts already holding the final score
  assign done     = done_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; a reply beats both tx completion and timeout in the same cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SEND;
      SEND:    state_nx = WAIT_TX;
      WAIT_TX: begin
        if (rx_done_tick || timer_exp) state_nx = CHECK;
        else if (tx_done_tick)         state_nx = WAIT_RX;
      end
      WAIT_RX: if (rx_done_tick || timer_exp) state_nx = CHECK;
      CHECK:   state_nx = (remaining == 9'd1) ? IDLE : SEND;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: byte sequencing, reply capture, timeout timer and scoring
  always_ff @(posedge clk) begin
    if (reset) begin
      w_data    <= '0;
      ok_cnt    <= '0;
      err_cnt   <= '0;
      to_cnt    <= '0;
      timer     <= '0;
      remaining <= '0;
      rx_byte   <= '0;
      timed_out <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ok_cnt    <= '0;
            err_cnt   <= '0;
            to_cnt    <= '0;
            remaining <= (num_bytes == 8'd0) ? 9'd256 : {1'b0, num_bytes};
            w_data    <= SEED;
          end
        end
        SEND: begin
          timer     <= '0;
          timed_out <= 1'b0;
        end
        WAIT_TX, WAIT_RX: begin
          timer <= timer + 1'b1;
          if (rx_done_tick)   rx_byte   <= r_data;
          else if (timer_exp) timed_out <= 1'b1;
        end
        CHECK: begin
          if (timed_out)               to_cnt  <= to_cnt + 9'd1;
          else if (rx_byte == expected) ok_cnt <= ok_cnt + 9'd1;
          else                         err_cnt <= err_cnt + 9'd1;
          remaining <= remaining - 9'd1;
          if (remaining == 9'd1) done_r <= 1'b1;
          else                   w_data <= w_data + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Self-checking bench for uart_echo_tester: a scripted responder answers each
// transmitted byte after a planned delay, and the bench predicts the byte stream,
// inter-byte spacing and final ok/err/timeout tallies from the exchange plan.
module tb_uart_echo_tester;

  localparam logic [7:0] SEED_TB = 8'hFE;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_bytes = 8'd0;
  logic       tx_done_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] r_data = 8'd0;
  logic       tx_start, busy, done;
  logic [7:0] w_data;
  logic [8:0] ok_cnt, err_cnt, to_cnt;

  uart_echo_tester #(.SEED(SEED_TB), .TIMEOUT(TMO), .TO_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .num_bytes(num_bytes),
    .tx_done_tick(tx_done_tick), .rx_done_tick(rx_done_tick), .r_data(r_data),
    .tx_start(tx_start), .w_data(w_data), .busy(busy), .done(done),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt), .to_cnt(to_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Exchange plan, one entry per byte of the run
  int plan_dly[256];
  int plan_off[256];
  int plan_txd[256];
  bit plan_sil[256];

  // Responder
  bit       resp_en = 1'b0;
  int       idx = 0;
  int       txc = 0;
  int       rxc = 0;
  logic [7:0] pend = 8'd0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        tx_done_tick = 1'b0;
        rx_done_tick = 1'b0;
        if (txc > 0) begin txc--; if (txc == 0) tx_done_tick = 1'b1; end
        if (rxc > 0) begin
          rxc--;
          if (rxc == 0) begin rx_done_tick = 1'b1; r_data = pend; end
        end
        if (tx_start && idx < 256) begin
          txc = plan_txd[idx];
          if (!plan_sil[idx]) begin
            rxc  = plan_dly[idx];
            pend = w_data + 8'(plan_off[idx]);
          end else rxc = 0;
          idx++;
        end
      end
    end
  end

  // Monitor
  int   cyc = 0;
  bit   prev_tx = 1'b0;
  int   done_seen = 0;
  int   snap_ok, snap_err, snap_to, snap_w, snap_busy;
  logic [7:0] txq[$];
  int   cycq[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start) begin
        chk("tx_start_single", int'(prev_tx), 0);
        txq.push_back(w_data);
        cycq.push_back(cyc);
      end
      prev_tx = tx_start;
      if (done) begin
        done_seen++;
        snap_ok = ok_cnt; snap_err = err_cnt; snap_to = to_cnt;
        snap_w = w_data; snap_busy = busy;
      end
    end
  end

  task automatic fill_plan(input int len, input int dly, input int err_pos, input int sil_pos);
    for (int k = 0; k < 256; k++) begin
      plan_dly[k] = dly;
      plan_txd[k] = (dly < 3) ? dly : 3;
      plan_off[k] = (k == err_pos) ? 2 : 1;
      plan_sil[k] = (k == sil_pos);
    end
  endtask

  task automatic run_case(input int n, input int e_ok, input int e_err, input int e_to,
                          input bit poke, input string tag);
    int len;
    int budget;
    len = (n == 0) ? 256 : n;
    budget = 70 * len + 20;
    txq.delete(); cycq.delete();
    done_seen = 0; idx = 0; txc = 0; rxc = 0;
    resp_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; num_bytes = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < budget && done_seen == 0; i++) begin
      @(posedge clk); #1;
      start = (poke && i == 5);
      if (poke && i == 5) num_bytes = 8'd9;
    end
    start = 1'b0;
    if (done_seen == 0) begin
      chk({tag, "_done_timeout"}, 0, 1);
      resp_en = 1'b0; tx_done_tick = 1'b0; rx_done_tick = 1'b0;
      return;
    end
    repeat (4) @(posedge clk);
    #1;
    resp_en = 1'b0; tx_done_tick = 1'b0; rx_done_tick = 1'b0;
    chk({tag, "_done_pulses"}, done_seen, 1);
    chk({tag, "_ok"}, snap_ok, e_ok);
    chk({tag, "_err"}, snap_err, e_err);
    chk({tag, "_to"}, snap_to, e_to);
    chk({tag, "_busy_at_done"}, snap_busy, 0);
    chk({tag, "_wdata_final"}, snap_w, int'(8'(SEED_TB + 8'(len - 1))));
    chk({tag, "_tx_count"}, txq.size(), len);
    for (int k = 0; k < len && k < txq.size(); k++)
      chk($sformatf("%s_wdata%0d", tag, k), int'(txq[k]), int'(8'(SEED_TB + 8'(k))));
    // spacing between SENDs: 1 SEND + wait (reply delay, or full timeout window) + 1 CHECK
    for (int k = 1; k < len && k < cycq.size(); k++)
      chk($sformatf("%s_gap%0d", tag, k), cycq[k] - cycq[k-1],
          plan_sil[k-1] ? TMO + 2 : plan_dly[k-1] + 2);
  endtask

  typedef struct {
    int n; int dly; int err_pos; int sil_pos; bit poke;
    int e_ok; int e_err; int e_to; string tag;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4,  10, -1, -1, 1'b0, 4,   0, 0, "four_ok"};
    vecs[1] = '{3,   5, -1, -1, 1'b0, 3,   0, 0, "wrap3"};
    vecs[2] = '{5,   7,  2, -1, 1'b0, 4,   1, 0, "bad_reply"};
    vecs[3] = '{3,   6, -1,  1, 1'b0, 2,   0, 1, "silent"};
    vecs[4] = '{0,   2, -1, -1, 1'b0, 256, 0, 0, "full256"};
    vecs[5] = '{2,  64, -1, -1, 1'b0, 2,   0, 0, "rx_at_timeout"};
    vecs[6] = '{2,  10, -1, -1, 1'b1, 2,   0, 0, "start_while_busy"};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wdata", w_data, 0);
    chk("rst_ok", ok_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_to", to_cnt, 0);

    foreach (vecs[v]) begin
      fill_plan((vecs[v].n == 0) ? 256 : vecs[v].n, vecs[v].dly, vecs[v].err_pos, vecs[v].sil_pos);
      run_case(vecs[v].n, vecs[v].e_ok, vecs[v].e_err, vecs[v].e_to, vecs[v].poke, vecs[v].tag);
    end

    // Ticks while idle must be ignored; counts from the last run must hold
    txq.delete(); done_seen = 0;
    @(posedge clk); #1;
    rx_done_tick = 1'b1; tx_done_tick = 1'b1; r_data = 8'h55;
    @(posedge clk); #1;
    rx_done_tick = 1'b0; tx_done_tick = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_no_tx", txq.size(), 0);
    chk("idle_no_done", done_seen, 0);
    chk("idle_ok_hold", ok_cnt, 2);
    chk("idle_err_hold", err_cnt, 0);

    // Randomized runs scored by the plan-level model
    for (int r = 0; r < 6; r++) begin
      int n, m_ok, m_err, m_to;
      n = $urandom_range(1, 12);
      m_ok = 0; m_err = 0; m_to = 0;
      for (int k = 0; k < 256; k++) begin
        plan_dly[k] = $urandom_range(1, 50);
        plan_txd[k] = $urandom_range(1, plan_dly[k]);
        plan_sil[k] = ($urandom_range(0, 7) == 0);
        plan_off[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 255) : 1;
      end
      for (int k = 0; k < n; k++) begin
        if (plan_sil[k])           m_to++;
        else if (plan_off[k] == 1) m_ok++;
        else                       m_err++;
      end
      run_case(n, m_ok, m_err, m_to, 1'b0, $sformatf("rand%0d", r));
    end

    // Reset in the middle of a run while waiting for a reply
    fill_plan(5, 20, -1, -1);
    idx = 0; txc = 0; rxc = 0; resp_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; num_bytes = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 400 && ok_cnt != 9'd2; i++) @(posedge clk);
    chk("midrun_reached", ok_cnt, 2);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    resp_en = 1'b0; tx_done_tick = 1'b0; rx_done_tick = 1'b0; rxc = 0; txc = 0;
    done_seen = 0; txq.delete();
    @(negedge clk);
    chk("midrst_tx_start", tx_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ok", ok_cnt, 0);
    chk("midrst_wdata", w_data, 0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_done", done_seen, 0);
    chk("midrst_no_tx", txq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
